// File: rtl/ex_lsu.sv
// ex_lsu: execute-stage load/store unit for RV32I loads and stores.
// Issues one req/gnt/rvalid data-bus access and holds the pipeline until it retires.
module ex_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic [31:0] reg2_rdata_i,
    input  logic        flush_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        hold_req_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        misalign_o,
    output logic        bus_err_o
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t state_q, state_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] ea;
    logic        is_load, is_store, mis, detect, timeout;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [15:0] lane;
    logic [31:0] ext;

    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  be_q;
    logic [4:0]  rd_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        load_q, mis_q, err_q, flush_q;
    logic [CW-1:0] cnt_q;

    logic unused_inst;
    assign unused_inst = ^inst_i[31:15];

    always_comb begin
        opcode   = inst_i[6:0];
        funct3   = inst_i[14:12];
        ea       = op1_i + op2_i;
        is_load  = (opcode == OP_LOAD) &&
                   (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_store = (opcode == OP_STORE) &&
                   (funct3 inside {3'b000, 3'b001, 3'b010});
        mis      = (funct3[1:0] == 2'b01 && ea[0]) ||
                   (funct3[1:0] == 2'b10 && ea[1:0] != 2'b00);
        be_d     = 4'b1111;
        wdata_d  = reg2_rdata_i;
        case (funct3[1:0])
            2'b00: begin
                be_d    = 4'b0001 << ea[1:0];
                wdata_d = {4{reg2_rdata_i[7:0]}};
            end
            2'b01: begin
                be_d    = ea[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{reg2_rdata_i[15:0]}};
            end
            default: ;
        endcase
        // Gate with rst so nothing asserts while reset is held
        detect  = rst && (state_q == S_IDLE) && (is_load || is_store) && !flush_i;
        timeout = (cnt_q == CW'(TIMEOUT - 1));
    end

    always_comb begin
        lane = 16'(mem_rdata_i >> {off_q, 3'b000});
        case (f3_q)
            3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ext = {24'b0, lane[7:0]};
            3'b101:  ext = {16'b0, lane[15:0]};
            default: ext = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (detect) state_d = mis ? S_DONE : S_REQ;
            S_REQ: begin
                if (flush_i)        state_d = S_IDLE;
                else if (mem_gnt_i) state_d = load_q ? S_WAIT : S_DONE;
                else if (timeout)   state_d = S_DONE;
            end
            S_WAIT: if (mem_rvalid_i || timeout) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            load_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (detect) begin
                    addr_q  <= {ea[31:2], 2'b00};
                    be_q    <= be_d;
                    wdata_q <= wdata_d;
                    rd_q    <= inst_i[11:7];
                    f3_q    <= funct3;
                    off_q   <= ea[1:0];
                    load_q  <= is_load;
                    mis_q   <= mis;
                    err_q   <= 1'b0;
                    flush_q <= 1'b0;
                    cnt_q   <= '0;
                end
                S_REQ: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (!flush_i && !mem_gnt_i && timeout) err_q <= 1'b1;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    // A flushed load still drains its response, but never writes back
                    if (flush_i) flush_q <= 1'b1;
                    if (mem_rvalid_i) rdata_q <= ext;
                    else if (timeout) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_req_o  = (state_q == S_REQ);
        mem_we_o   = (state_q == S_REQ) && !load_q;
        hold_req_o = detect || (state_q == S_REQ) || (state_q == S_WAIT);
        reg_we_o   = (state_q == S_DONE) && load_q && (rd_q != 5'd0) &&
                     !flush_q && !err_q && !mis_q;
        misalign_o = (state_q == S_DONE) && mis_q;
        bus_err_o  = (state_q == S_DONE) && err_q;
    end

    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign reg_waddr_o = rd_q;
    assign reg_wdata_o = rdata_q;
endmodule

// File: tb/tb_ex_lsu.sv
// tb_ex_lsu: directed table, reset sequences and random accesses for ex_lsu.
// Expected results come from constants or a cycle-count level model of the unit.
module tb_ex_lsu;
    localparam int TO = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i, op1_i, op2_i, reg2_rdata_i;
    logic        flush_i, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_req_o, mem_we_o, hold_req_o, reg_we_o, misalign_o, bus_err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, reg_wdata_o;
    logic [3:0]  mem_be_o;
    logic [4:0]  reg_waddr_o;

    always #5 clk = ~clk;

    ex_lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .op1_i(op1_i), .op2_i(op2_i),
        .reg2_rdata_i(reg2_rdata_i), .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .hold_req_o(hold_req_o), .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o),
        .reg_wdata_o(reg_wdata_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    // g: REQ cycles before gnt, n: cycles from gnt to rvalid, fl: flush cycle (-1 none)
    typedef struct {
        logic [31:0] inst, op1, op2, rs2, rdata;
        int g, n, fl;
    } stim_t;

    typedef struct {
        int done, req, we, mis, err;
        logic [31:0] res;
        logic [4:0]  waddr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        mwe;
    } res_t;

    typedef struct { stim_t s; res_t e; } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    vec_t tbl[15];
    logic [2:0] lf3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    function automatic logic [31:0] ld(input logic [2:0] f3, input logic [4:0] rd);
        return {17'b0, f3, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] st(input logic [2:0] f3);
        return {17'b0, f3, 5'b0, 7'b0100011};
    endfunction

    function automatic stim_t mk_s(input logic [31:0] inst, op1, op2, rs2, rdata,
                                   input int g, n, fl);
        stim_t s;
        s.inst = inst; s.op1 = op1; s.op2 = op2; s.rs2 = rs2; s.rdata = rdata;
        s.g = g; s.n = n; s.fl = fl;
        return s;
    endfunction

    function automatic res_t mk_e(input int done, req, we, mis, err,
                                  input logic [31:0] res, input logic [4:0] waddr,
                                  input logic [31:0] addr, input logic [3:0] be,
                                  input logic [31:0] wd, input logic mwe);
        res_t e;
        e.done = done; e.req = req; e.we = we; e.mis = mis; e.err = err;
        e.res = res; e.waddr = waddr; e.addr = addr; e.be = be; e.wd = wd;
        e.mwe = mwe;
        return e;
    endfunction

    // Outcome of an access in cycles counted from the detection cycle (cycle 0)
    function automatic res_t model(input stim_t s);
        res_t e;
        logic [31:0] ea, sh, v;
        logic [2:0]  f3;
        logic [4:0]  rd;
        int off, sz;
        bit ld_op, fw;
        e = mk_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        f3 = s.inst[14:12];
        rd = s.inst[11:7];
        ld_op = (s.inst[6:0] == 7'b0000011);
        ea = s.op1 + s.op2;
        off = int'(ea % 4);
        sz = 1 << f3[1:0];
        if (ea % sz != 0) begin
            e.done = 1; e.mis = 1;
            return e;
        end
        e.addr = ea - off;
        e.be = 4'(((1 << sz) - 1) << off);
        e.mwe = !ld_op;
        if (sz == 1)      e.wd = s.rs2[7:0] * 32'h0101_0101;
        else if (sz == 2) e.wd = s.rs2[15:0] * 32'h0001_0001;
        else              e.wd = s.rs2;
        if (s.fl >= 1 && s.fl <= s.g + 1 && s.fl <= TO) begin
            e.req = s.fl; e.done = s.fl + 1;
            return e;
        end
        if (s.g + 1 > TO) begin
            e.req = TO; e.done = TO + 1; e.err = 1;
            return e;
        end
        e.req = s.g + 1;
        if (!ld_op) begin
            e.done = s.g + 2;
            return e;
        end
        if (s.g + 1 + s.n > TO) begin
            e.done = TO + 1; e.err = 1;
            return e;
        end
        e.done = s.g + 2 + s.n;
        fw = (s.fl > s.g + 1) && (s.fl <= s.g + 1 + s.n);
        sh = s.rdata >> (8 * off);
        case (f3)
            3'd0: begin v = sh & 255;   if (v >= 128)   v = v - 256;   end
            3'd1: begin v = sh & 65535; if (v >= 32768) v = v - 65536; end
            3'd4: v = sh & 255;
            3'd5: v = sh & 65535;
            default: v = sh;
        endcase
        if (rd != 0 && !fw) begin
            e.we = 1; e.res = v; e.waddr = rd;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string t);
        chk({t, " ctl"}, {26'b0, mem_req_o, mem_we_o, hold_req_o, reg_we_o,
                          misalign_o, bus_err_o}, 32'h0);
        chk({t, " addr"}, mem_addr_o, 32'h0);
        chk({t, " be"}, {28'b0, mem_be_o}, 32'h0);
        chk({t, " wdata"}, mem_wdata_o, 32'h0);
        chk({t, " reg_wdata"}, reg_wdata_o, 32'h0);
        chk({t, " reg_waddr"}, {27'b0, reg_waddr_o}, 32'h0);
    endtask

    task automatic run_access(input stim_t s, output res_t o, output logic hold0,
                              output logic quiet);
        int gnt_at;
        logic req, hold, we;
        o = mk_e(-1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        gnt_at = -1;
        @(negedge clk);
        inst_i = s.inst; op1_i = s.op1; op2_i = s.op2; reg2_rdata_i = s.rs2;
        flush_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
        #1 hold0 = hold_req_o;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            req = mem_req_o; hold = hold_req_o; we = reg_we_o;
            mem_gnt_i = 0; mem_rvalid_i = 0; flush_i = 0;
            if (we) begin
                o.we++; o.res = reg_wdata_o; o.waddr = reg_waddr_o;
            end
            if (misalign_o) o.mis++;
            if (bus_err_o) o.err++;
            if (req) begin
                if (o.req == 0) begin
                    o.addr = mem_addr_o; o.be = mem_be_o;
                    o.wd = mem_wdata_o; o.mwe = mem_we_o;
                end
                if (o.req == s.g) begin
                    mem_gnt_i = 1; gnt_at = k;
                end
                o.req++;
            end
            if (gnt_at >= 0 && k == gnt_at + s.n && !o.mwe) begin
                mem_rvalid_i = 1; mem_rdata_i = s.rdata;
            end
            if (k == s.fl) begin
                flush_i = 1; inst_i = NOP;
            end
            if (!hold) begin
                o.done = k; inst_i = NOP;
                break;
            end
        end
        @(negedge clk);
        quiet = !mem_req_o && !reg_we_o && !misalign_o && !bus_err_o && !hold_req_o;
        mem_gnt_i = 0; mem_rvalid_i = 0; flush_i = 0; inst_i = NOP;
    endtask

    task automatic compare(input string t, input res_t o, input res_t e);
        chk({t, " done_cycle"}, o.done, e.done);
        chk({t, " req_cycles"}, o.req, e.req);
        chk({t, " reg_we_count"}, o.we, e.we);
        chk({t, " misalign_count"}, o.mis, e.mis);
        chk({t, " bus_err_count"}, o.err, e.err);
        if (e.we != 0) begin
            chk({t, " reg_waddr"}, {27'b0, o.waddr}, {27'b0, e.waddr});
            chk({t, " reg_wdata"}, o.res, e.res);
        end
        if (e.req != 0) begin
            chk({t, " addr"}, o.addr, e.addr);
            chk({t, " be"}, {28'b0, o.be}, {28'b0, e.be});
            chk({t, " we"}, {31'b0, o.mwe}, {31'b0, e.mwe});
            if (e.mwe) chk({t, " wdata"}, o.wd, e.wd);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        stim_t s;
        res_t  o, e;
        logic  h, q, late_we;
        int    pick;

        tbl[0]  = '{mk_s(ld(3'd2, 5'd5), 32'h1000, 32'h4, 0, 32'hDEADBEEF, 0, 2, -1),
                    mk_e(4, 1, 1, 0, 0, 32'hDEADBEEF, 5, 32'h1004, 4'hF, 0, 0)};
        tbl[1]  = '{mk_s(ld(3'd0, 5'd6), 32'h1000, 32'h3, 0, 32'h80123456, 0, 1, -1),
                    mk_e(3, 1, 1, 0, 0, 32'hFFFFFF80, 6, 32'h1000, 4'h8, 0, 0)};
        tbl[2]  = '{mk_s(ld(3'd4, 5'd7), 32'h1000, 32'h3, 0, 32'h80123456, 0, 1, -1),
                    mk_e(3, 1, 1, 0, 0, 32'h00000080, 7, 32'h1000, 4'h8, 0, 0)};
        tbl[3]  = '{mk_s(ld(3'd1, 5'd8), 32'h1000, 32'h2, 0, 32'h80011234, 1, 1, -1),
                    mk_e(4, 2, 1, 0, 0, 32'hFFFF8001, 8, 32'h1000, 4'hC, 0, 0)};
        tbl[4]  = '{mk_s(ld(3'd5, 5'd9), 32'h1000, 32'h0, 0, 32'h1234F00D, 0, 1, -1),
                    mk_e(3, 1, 1, 0, 0, 32'h0000F00D, 9, 32'h1000, 4'h3, 0, 0)};
        tbl[5]  = '{mk_s(st(3'd0), 32'h2000, 32'h2, 32'h123456AB, 0, 0, 1, -1),
                    mk_e(2, 1, 0, 0, 0, 0, 0, 32'h2000, 4'h4, 32'hABABABAB, 1)};
        tbl[6]  = '{mk_s(st(3'd1), 32'h2000, 32'h2, 32'h0000BEEF, 0, 2, 1, -1),
                    mk_e(4, 3, 0, 0, 0, 0, 0, 32'h2000, 4'hC, 32'hBEEFBEEF, 1)};
        tbl[7]  = '{mk_s(st(3'd2), 32'h2004, 32'hFFFFFFFC, 32'hCAFEF00D, 0, 0, 1, -1),
                    mk_e(2, 1, 0, 0, 0, 0, 0, 32'h2000, 4'hF, 32'hCAFEF00D, 1)};
        tbl[8]  = '{mk_s(ld(3'd1, 5'd10), 32'h1000, 32'h1, 0, 0, 0, 1, -1),
                    mk_e(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{mk_s(st(3'd2), 32'h2000, 32'h2, 32'h11, 0, 0, 1, -1),
                    mk_e(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0)};
        tbl[10] = '{mk_s(ld(3'd2, 5'd0), 32'h3000, 32'h8, 0, 32'h11111111, 0, 1, -1),
                    mk_e(3, 1, 0, 0, 0, 0, 0, 32'h3008, 4'hF, 0, 0)};
        tbl[11] = '{mk_s(st(3'd2), 32'h4000, 32'h0, 32'h55, 0, 99, 1, -1),
                    mk_e(9, 8, 0, 0, 1, 0, 0, 32'h4000, 4'hF, 32'h55, 1)};
        tbl[12] = '{mk_s(ld(3'd2, 5'd3), 32'h4000, 32'h4, 0, 0, 0, 99, -1),
                    mk_e(9, 1, 0, 0, 1, 0, 0, 32'h4004, 4'hF, 0, 0)};
        tbl[13] = '{mk_s(ld(3'd2, 5'd4), 32'h5000, 32'h0, 0, 32'h77, 1, 1, 1),
                    mk_e(2, 1, 0, 0, 0, 0, 0, 32'h5000, 4'hF, 0, 0)};
        tbl[14] = '{mk_s(ld(3'd2, 5'd4), 32'h5000, 32'h4, 0, 32'h12345678, 0, 2, 2),
                    mk_e(4, 1, 0, 0, 0, 0, 0, 32'h5004, 4'hF, 0, 0)};

        rst = 0;
        inst_i = ld(3'd2, 5'd1); op1_i = 32'h1000; op2_i = 0; reg2_rdata_i = 0;
        flush_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        inst_i = NOP;
        rst = 1;

        for (int i = 0; i < 15; i++) begin
            run_access(tbl[i].s, o, h, q);
            compare($sformatf("vec%0d", i), o, tbl[i].e);
            chk($sformatf("vec%0d hold_at_detect", i), {31'b0, h}, 32'h1);
            chk($sformatf("vec%0d quiet_after", i), {31'b0, q}, 32'h1);
        end

        // Reset while a load waits for its response
        @(negedge clk);
        inst_i = ld(3'd2, 5'd5); op1_i = 32'h6000; op2_i = 0;
        @(negedge clk);
        chk("rst_seq req", {31'b0, mem_req_o}, 32'h1);
        mem_gnt_i = 1;
        @(negedge clk);
        mem_gnt_i = 0;
        chk("rst_seq hold_in_wait", {31'b0, hold_req_o}, 32'h1);
        #2 rst = 0;
        #1 chk_zero("mid_wait_reset");
        @(negedge clk);
        inst_i = NOP;
        rst = 1;
        mem_rvalid_i = 1; mem_rdata_i = 32'hBAD0BAD0;
        late_we = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (reg_we_o || hold_req_o || mem_req_o) late_we = 1;
            mem_rvalid_i = 0;
        end
        chk("late_rvalid no_activity", {31'b0, late_we}, 32'h0);
        run_access(tbl[0].s, o, h, q);
        compare("after_reset", o, tbl[0].e);

        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 7);
            if (pick < 5) s.inst = ld(lf3[pick], 5'($urandom));
            else          s.inst = st(3'(pick - 5));
            s.op1 = $urandom;
            s.op2 = $urandom_range(0, 7);
            s.rs2 = $urandom;
            s.rdata = $urandom;
            s.g = $urandom_range(0, 2);
            s.n = $urandom_range(1, 3);
            s.fl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : -1;
            e = model(s);
            run_access(s, o, h, q);
            compare($sformatf("rand%0d", i), o, e);
            chk($sformatf("rand%0d quiet_after", i), {31'b0, q}, 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
